bcd_display_scheduler: RTL and testbench

//  Drives an 8-digit multiplexed 7-segment display from two binary counters (number_1, number_2 from

---
 rtl/bcd_display_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_bcd_display_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scheduler.sv
// Purpose: converts two 14-bit binary counts to BCD and scans them onto an 8-digit multiplexed 7-seg display.
// Latency: IDLE sample -> display regs 15 cycles (16-cycle conversion pass); display regs -> pins 1 cycle.
// Backpressure: none; free-running, inputs changing mid-pass are ignored until the next IDLE sample.
//
// Ports:
//   clk        system clock, rising edge
//   rst_ext    synchronous active-low reset
//   number_1   value shown on digits 0-3 (clamped to 9999, dp on digit 3 marks overflow)
//   number_2   value shown on digits 4-7 (clamped to 9999, dp on digit 7 marks overflow)
//   digit_sel  active-low one-hot digit anodes
//   segments   active-low cathodes, gfedcba
//   dp         active-low decimal point
//   bcd_valid  one-cycle pulse after the display registers have been refreshed
module bcd_display_scheduler #(
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_ext,
  input  logic [13:0] number_1,
  input  logic [13:0] number_2,
  output logic [7:0]  digit_sel,
  output logic [6:0]  segments,
  output logic        dp,
  output logic        bcd_valid
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [13:0] MAX_VAL = 14'd9999;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
  } state_e;

  // Conversion state
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] bin1_q, bin1_d, bin2_q, bin2_d;
  logic [15:0] bcd1_q, bcd1_d, bcd2_q, bcd2_d;
  logic        ovf1_q, ovf1_d, ovf2_q, ovf2_d;

  // Display registers, only written in LOAD so both numbers change together
  logic [15:0] disp1_q, disp1_d, disp2_q, disp2_d;
  logic        dovf1_q, dovf1_d, dovf2_q, dovf2_d;
  logic        valid_q, valid_d;

  // Refresh scheduler
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;

  // Output registers
  logic [7:0] sel_q, sel_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift
  function automatic logic [15:0] dd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Conversion FSM: next state and datapath
  logic [15:0] adj1, adj2;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin1_d  = bin1_q;
    bin2_d  = bin2_q;
    bcd1_d  = bcd1_q;
    bcd2_d  = bcd2_q;
    ovf1_d  = ovf1_q;
    ovf2_d  = ovf2_q;
    disp1_d = disp1_q;
    disp2_d = disp2_q;
    dovf1_d = dovf1_q;
    dovf2_d = dovf2_q;
    valid_d = 1'b0;
    adj1    = dd_adjust(bcd1_q);
    adj2    = dd_adjust(bcd2_q);

    case (state_q)
      S_IDLE: begin
        ovf1_d  = (number_1 > MAX_VAL);
        ovf2_d  = (number_2 > MAX_VAL);
        bin1_d  = (number_1 > MAX_VAL) ? MAX_VAL : number_1;
        bin2_d  = (number_2 > MAX_VAL) ? MAX_VAL : number_2;
        bcd1_d  = 16'h0;
        bcd2_d  = 16'h0;
        cnt_d   = 4'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {bcd1_d, bin1_d} = {adj1[14:0], bin1_q, 1'b0};
        {bcd2_d, bin2_d} = {adj2[14:0], bin2_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = S_LOAD;
      end
      S_LOAD: begin
        disp1_d = bcd1_q;
        disp2_d = bcd2_q;
        dovf1_d = ovf1_q;
        dovf2_d = ovf2_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Refresh scheduler and digit decode
  logic        div_tc;
  logic [15:0] cur_bcd, upper;
  logic [3:0]  cur_nib;
  logic        blank;

  always_comb begin
    div_tc  = (div_q == DIV_W'(REFRESH_DIV - 1));
    div_d   = div_tc ? '0 : div_q + 1'b1;
    idx_d   = div_tc ? idx_q + 3'd1 : idx_q;

    cur_bcd = idx_q[2] ? disp2_q : disp1_q;
    cur_nib = cur_bcd[{idx_q[1:0], 2'b00} +: 4];
    // Blank when this nibble and every higher one is zero; the ones digit is never blanked
    upper   = cur_bcd >> {idx_q[1:0], 2'b00};
    blank   = LZ_BLANK && (idx_q[1:0] != 2'd0) && (upper == 16'h0);

    sel_d   = ~(8'b1 << idx_q);
    seg_d   = blank ? 7'h7F : seg_code(cur_nib);
    dp_d    = ~(((idx_q == 3'd3) && dovf1_q) || ((idx_q == 3'd7) && dovf2_q));
  end

  always_ff @(posedge clk) begin
    if (!rst_ext) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      bin1_q  <= 14'd0;
      bin2_q  <= 14'd0;
      bcd1_q  <= 16'h0;
      bcd2_q  <= 16'h0;
      ovf1_q  <= 1'b0;
      ovf2_q  <= 1'b0;
      disp1_q <= 16'h0;
      disp2_q <= 16'h0;
      dovf1_q <= 1'b0;
      dovf2_q <= 1'b0;
      valid_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= 3'd0;
      sel_q   <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin1_q  <= bin1_d;
      bin2_q  <= bin2_d;
      bcd1_q  <= bcd1_d;
      bcd2_q  <= bcd2_d;
      ovf1_q  <= ovf1_d;
      ovf2_q  <= ovf2_d;
      disp1_q <= disp1_d;
      disp2_q <= disp2_d;
      dovf1_q <= dovf1_d;
      dovf2_q <= dovf2_d;
      valid_q <= valid_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign digit_sel = sel_q;
  assign segments  = seg_q;
  assign dp        = dp_q;
  assign bcd_valid = valid_q;

endmodule

// File: tb/tb_bcd_display_scheduler.sv
module tb_bcd_display_scheduler;

  logic        clk = 1'b0;
  logic        rst_ext;
  logic [13:0] number_1, number_2;
  logic [7:0]  digit_sel;
  logic [6:0]  segments;
  logic        dp;
  logic        bcd_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0][6:0] seg;
    logic [7:0]      dp;
  } disp_t;

  disp_t exp_q[$];

  bcd_display_scheduler #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst_ext(rst_ext), .number_1(number_1), .number_2(number_2),
    .digit_sel(digit_sel), .segments(segments), .dp(dp), .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference display image built from decimal arithmetic
  function automatic disp_t model(input int a, input int b);
    disp_t r;
    int v, p;
    bit ovf;
    r.dp = 8'hFF;
    for (int ch = 0; ch < 2; ch++) begin
      v = (ch == 0) ? a : b;
      ovf = (v > 9999);
      if (ovf) v = 9999;
      p = 1;
      for (int k = 0; k < 4; k++) begin
        if (k > 0 && v < p) r.seg[ch*4+k] = 7'h7F;
        else                r.seg[ch*4+k] = seg_of((v / p) % 10);
        p = p * 10;
      end
      if (ovf) r.dp[ch*4+3] = 1'b0;
    end
    return r;
  endfunction

  function automatic int sel_idx(input logic [7:0] s);
    logic [7:0] m;
    for (int k = 0; k < 8; k++) begin
      m = ~(8'b1 << k);
      if (s === m) return k;
    end
    return -1;
  endfunction

  // Waits for the next bcd_valid pulse; cycles = -1 on timeout
  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    while (1) begin
      @(negedge clk);
      cycles++;
      if (bcd_valid === 1'b1) return;
      if (cycles >= budget) begin
        cycles = -1;
        return;
      end
    end
  endtask

  // Observes one full scan (32 cycles) and records what each digit showed
  task automatic capture_scan(output disp_t got, output logic [7:0] seen,
                              output int bad_sel, output int torn);
    int idx;
    got = '1;
    seen = 8'h00;
    bad_sel = 0;
    torn = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      idx = sel_idx(digit_sel);
      if (idx < 0) bad_sel++;
      else begin
        if (seen[idx] && (got.seg[idx] !== segments || got.dp[idx] !== dp)) torn++;
        got.seg[idx] = segments;
        got.dp[idx]  = dp;
        seen[idx]    = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_ext = 1'b0;
    number_1 = 14'd0;
    number_2 = 14'd0;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if ({digit_sel, segments, dp, bcd_valid} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_outputs: got sel=%h seg=%h dp=%b vld=%b, want FF 7F 1 0",
                 digit_sel, segments, dp, bcd_valid);
      end
    end
  endtask

  task automatic test_release();
    int cyc;
    disp_t exp, got;
    logic [7:0] seen;
    int bad, torn;
    number_1 = 14'd1234;
    number_2 = 14'd0;
    exp_q.push_back(model(1234, 0));
    rst_ext = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (digit_sel !== 8'hFE || segments !== 7'h40 || dp !== 1'b1) begin
          n_fail++;
          $display("FAIL first_cycle: got sel=%h seg=%h dp=%b, want FE 40 1", digit_sel, segments, dp);
        end
      end
      if (bcd_valid === 1'b1) begin
        cyc = c;
        break;
      end
    end
    n_checks++;
    if (cyc != 16) begin
      n_fail++;
      $display("FAIL first_valid_latency: got %0d cycles, want 16", cyc);
    end
    exp = exp_q.pop_front();
    @(negedge clk);
    n_checks++;
    if (bcd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_pulse_width: bcd_valid=%b one cycle later, want 0", bcd_valid);
    end
    capture_scan(got, seen, bad, torn);
    n_checks++;
    if (got.seg !== exp.seg) begin
      n_fail++;
      $display("FAIL scan_1234_seg: got %h want %h", got.seg, exp.seg);
    end
    n_checks++;
    if (got.dp !== exp.dp || seen !== 8'hFF || bad != 0 || torn != 0) begin
      n_fail++;
      $display("FAIL scan_1234_misc: dp=%h seen=%h bad=%0d torn=%0d, want dp=%h seen=FF 0 0",
               got.dp, seen, bad, torn, exp.dp);
    end
  endtask

  // Drives a pair, waits until it has certainly been loaded, then checks a full scan
  task automatic test_patterns();
    int pa[4] = '{1234, 50, 9999, 8};
    int pb[4] = '{16383, 1005, 10000, 600};
    disp_t exp, got;
    logic [7:0] seen;
    int bad, torn, c1, c2;
    for (int i = 0; i < 4; i++) begin
      number_1 = 14'(pa[i]);
      number_2 = 14'(pb[i]);
      exp_q.push_back(model(pa[i], pb[i]));
      wait_valid(40, c1);
      wait_valid(40, c2);
      n_checks++;
      if (c1 < 0 || c2 < 0) begin
        n_fail++;
        $display("FAIL pattern%0d_valid_timeout: got %0d/%0d, want both >0", i, c1, c2);
      end
      exp = exp_q.pop_front();
      capture_scan(got, seen, bad, torn);
      n_checks++;
      if (got.seg !== exp.seg) begin
        n_fail++;
        $display("FAIL pattern%0d_seg (%0d,%0d): got %h want %h", i, pa[i], pb[i], got.seg, exp.seg);
      end
      n_checks++;
      if (got.dp !== exp.dp || seen !== 8'hFF || bad != 0 || torn != 0) begin
        n_fail++;
        $display("FAIL pattern%0d_dp: dp=%h seen=%h bad=%0d torn=%0d, want dp=%h seen=FF 0 0",
                 i, got.dp, seen, bad, torn, exp.dp);
      end
    end
  endtask

  task automatic test_scan_order();
    logic [7:0] prev, want;
    int found;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      prev = digit_sel;
      @(negedge clk);
      if (digit_sel === 8'hFE && prev !== 8'hFE) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (found == 0) begin
      n_fail++;
      $display("FAIL scan_sync: got no transition into FE, want one within 40 cycles");
    end
    for (int i = 0; i < 33; i++) begin
      want = ~(8'b1 << ((i / 4) % 8));
      n_checks++;
      if (digit_sel !== want) begin
        n_fail++;
        $display("FAIL scan_order step %0d: got %h want %h", i, digit_sel, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_no_tear();
    disp_t cur;
    int c1, c2, idx, nvalid, sw_at, post;
    number_1 = 14'd1234;
    number_2 = 14'd0;
    exp_q.push_back(model(1234, 0));
    wait_valid(40, c1);
    wait_valid(40, c2);
    n_checks++;
    if (c1 < 0 || c2 < 0) begin
      n_fail++;
      $display("FAIL tear_setup_timeout: got %0d/%0d, want both >0", c1, c2);
    end
    cur = exp_q.pop_front();
    repeat (3) @(negedge clk);     // converter is now in SHIFT
    number_1 = 14'd5678;
    exp_q.push_back(model(5678, 0));
    nvalid = 0;
    sw_at = -1;
    post = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      idx = sel_idx(digit_sel);
      n_checks++;
      if (idx < 0 || segments !== cur.seg[idx] || dp !== cur.dp[idx]) begin
        n_fail++;
        $display("FAIL no_tear cycle %0d: sel=%h seg=%h dp=%b, want seg/dp of %s",
                 c, digit_sel, segments, dp, (sw_at < 0) ? "1234" : "5678");
      end
      if (sw_at >= 0) begin
        post++;
        if (post >= 20) break;
      end
      if (bcd_valid === 1'b1) begin
        nvalid++;
        if (nvalid == 2) begin
          sw_at = c;
          cur = exp_q.pop_front();
        end
      end
    end
    n_checks++;
    if (sw_at != 29) begin
      n_fail++;
      $display("FAIL no_tear_switch_point: got cycle %0d, want 29", sw_at);
    end
  endtask

  task automatic test_reset_mid();
    disp_t zero;
    int c1, c2, cyc, idx, bad;
    number_1 = 14'd1234;
    number_2 = 14'd0;
    exp_q.push_back(model(1234, 0));
    wait_valid(40, c1);
    wait_valid(40, c2);
    n_checks++;
    if (c1 < 0 || c2 < 0) begin
      n_fail++;
      $display("FAIL rmid_setup_timeout: got %0d/%0d, want both >0", c1, c2);
    end
    void'(exp_q.pop_front());
    repeat (5) @(negedge clk);
    rst_ext = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({digit_sel, segments, dp, bcd_valid} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rmid_reset_outputs: got sel=%h seg=%h dp=%b vld=%b, want FF 7F 1 0",
               digit_sel, segments, dp, bcd_valid);
    end
    exp_q.push_back(model(0, 0));
    rst_ext = 1'b1;
    zero = exp_q.pop_front();
    cyc = 0;
    bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (digit_sel !== 8'hFE) begin
          n_fail++;
          $display("FAIL rmid_first_sel: got %h want FE", digit_sel);
        end
      end
      if (c <= 16) begin
        idx = sel_idx(digit_sel);
        if (idx < 0 || segments !== zero.seg[idx] || dp !== zero.dp[idx]) bad++;
      end
      if (bcd_valid === 1'b1) begin
        cyc = c;
        break;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rmid_display_cleared: got %0d cycles not showing zero, want 0", bad);
    end
    n_checks++;
    if (cyc != 16) begin
      n_fail++;
      $display("FAIL rmid_valid_latency: got %0d cycles, want 16", cyc);
    end
  endtask

  initial begin
    rst_ext  = 1'b0;
    number_1 = 14'd0;
    number_2 = 14'd0;
    test_reset();
    test_release();
    test_patterns();
    test_scan_order();
    test_no_tear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
